vote_session: RTL and testbench

VOTE_SESSION -- requirements
Module: vote_session

---
 rtl/vote_session.sv | 123 ++++++++++++
 tb/tb_vote_session.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_session.sv
// rtl/vote_session.sv - three-voter yes/no session controller with debounced keys
module vote_session #(
    parameter int DB_CYCLES  = 1_000_000,
    parameter int WIN_CYCLES = 500_000_000
) (
    input  logic       CLK_50M,
    input  logic       RST_N,
    input  logic       KEY_START_N,
    input  logic       KEY_A_N,
    input  logic       KEY_B_N,
    input  logic       KEY_C_N,
    output logic [2:0] LED_VOTED,
    output logic [1:0] YES_CNT,
    output logic       BUSY,
    output logic       LED_PASS,
    output logic       LED_FAIL,
    output logic       DONE
);
    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int TW  = $clog2(WIN_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    localparam logic [TW-1:0]  T_LAST  = TW'(WIN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, VOTING, RESULT} state_t;

    // Key index 0 is the chair start key, 1..3 are voters A..C.
    logic [3:0]     keys_raw;
    logic [3:0]     sync1_q, sync2_q, db_q, press_q;
    logic [DBW-1:0] db_cnt_q [4];

    assign keys_raw = {KEY_C_N, KEY_B_N, KEY_A_N, KEY_START_N};

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= '1;
            sync2_q <= '1;
            db_q    <= '1;
            press_q <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q <= keys_raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 4; i++) begin
                press_q[i] <= 1'b0;
                if (sync2_q[i] != db_q[i]) begin
                    if (db_cnt_q[i] == DB_LAST) begin
                        db_q[i]     <= sync2_q[i];
                        db_cnt_q[i] <= '0;
                        // Only the released->pressed edge produces an event.
                        press_q[i]  <= db_q[i];
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + DBW'(1);
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    state_t        state_q;
    logic [2:0]    voted_q;
    logic [1:0]    yes_q;
    logic [TW-1:0] timer_q;
    logic          busy_q, pass_q, fail_q, done_q;
    logic [2:0]    accept_d;
    logic [1:0]    yes_d;

    always_comb begin
        accept_d = press_q[3:1] & ~voted_q;
        yes_d    = yes_q + 2'(accept_d[0]) + 2'(accept_d[1]) + 2'(accept_d[2]);
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            voted_q <= '0;
            yes_q   <= '0;
            timer_q <= '0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, RESULT: begin
                    if (press_q[0]) begin
                        state_q <= VOTING;
                        voted_q <= '0;
                        yes_q   <= '0;
                        timer_q <= '0;
                        busy_q  <= 1'b1;
                        pass_q  <= 1'b0;
                        fail_q  <= 1'b0;
                    end
                end
                VOTING: begin
                    voted_q <= voted_q | accept_d;
                    yes_q   <= yes_d;
                    // Votes landing on the expiry cycle still count toward the result.
                    if (voted_q == 3'b111 || timer_q == T_LAST) begin
                        state_q <= RESULT;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (yes_d >= 2'd2);
                        fail_q  <= (yes_d < 2'd2);
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign LED_VOTED = voted_q;
    assign YES_CNT   = yes_q;
    assign BUSY      = busy_q;
    assign LED_PASS  = pass_q;
    assign LED_FAIL  = fail_q;
    assign DONE      = done_q;
endmodule

// File: tb/tb_vote_session.sv
// tb/tb_vote_session.sv - randomized and directed bench for vote_session against a behavioural model
module tb_vote_session;
    localparam int DB  = 4;
    localparam int WIN = 100;

    logic       CLK_50M = 1'b0;
    logic       RST_N   = 1'b1;
    logic [3:0] kn      = 4'hF;
    logic       KEY_START_N, KEY_A_N, KEY_B_N, KEY_C_N;
    logic [2:0] LED_VOTED;
    logic [1:0] YES_CNT;
    logic       BUSY, LED_PASS, LED_FAIL, DONE;

    assign KEY_START_N = kn[0];
    assign KEY_A_N     = kn[1];
    assign KEY_B_N     = kn[2];
    assign KEY_C_N     = kn[3];

    always #10 CLK_50M = ~CLK_50M;

    vote_session #(.DB_CYCLES(DB), .WIN_CYCLES(WIN)) dut (
        .CLK_50M(CLK_50M), .RST_N(RST_N),
        .KEY_START_N(KEY_START_N), .KEY_A_N(KEY_A_N), .KEY_B_N(KEY_B_N), .KEY_C_N(KEY_C_N),
        .LED_VOTED(LED_VOTED), .YES_CNT(YES_CNT), .BUSY(BUSY),
        .LED_PASS(LED_PASS), .LED_FAIL(LED_FAIL), .DONE(DONE)
    );

    int checks = 0;
    int failures = 0;
    int busy_cycles = 0;
    int done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: keys seen through a two-sample delay, a level only accepted after
    // DB consecutive samples disagree with it, and a session of three irreversible votes.
    int         m_state;  // 0 idle, 1 voting, 2 result
    logic [2:0] m_voted;
    int         m_yes, m_timer;
    logic       m_done;
    logic [3:0] m_s1, m_s2, m_db, m_ev, m_use, m_new;
    int         m_run [4];
    logic       m_all;

    task automatic m_open();
        m_state = 1; m_voted = 0; m_yes = 0; m_timer = 0;
    endtask

    always @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            m_s1 = 4'hF; m_s2 = 4'hF; m_db = 4'hF; m_ev = 0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_state = 0; m_voted = 0; m_yes = 0; m_timer = 0; m_done = 0;
        end else begin
            m_use = m_ev;
            m_new = 0;
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] != m_db[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] >= DB) begin
                        m_db[i] = m_s2[i];
                        m_run[i] = 0;
                        if (m_db[i] == 1'b0) m_new[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = kn;
            m_ev = m_new;
            m_done = 0;
            if (m_state == 1) begin
                m_all = (m_voted == 3'b111);
                for (int v = 0; v < 3; v++)
                    if (m_use[v+1] && !m_voted[v]) begin
                        m_voted[v] = 1'b1;
                        m_yes++;
                    end
                if (m_all || m_timer == WIN - 1) begin
                    m_state = 2;
                    m_done = 1;
                end else begin
                    m_timer++;
                end
            end else if (m_use[0]) begin
                m_open();
            end
        end
    end

    function automatic logic [8:0] exp_vec();
        logic [1:0] y;
        y = m_yes[1:0];
        return {m_state == 1, m_state == 2 && m_yes >= 2, m_state == 2 && m_yes < 2, m_done, y, m_voted};
    endfunction

    wire [8:0] dut_vec = {BUSY, LED_PASS, LED_FAIL, DONE, YES_CNT, LED_VOTED};

    task automatic tick();
        @(negedge CLK_50M);
        check("cyc", 32'(dut_vec), 32'(exp_vec()));
        if (BUSY) busy_cycles++;
        if (DONE) done_cnt++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic hold(input logic [3:0] mask, input int n);
        kn = kn & ~mask;
        repeat (n) tick();
        kn = kn | mask;
    endtask

    task automatic start_session();
        int k;
        busy_cycles = 0;
        done_cnt = 0;
        kn[0] = 1'b0;
        k = 0;
        while (!BUSY && k < 20) begin
            tick();
            k++;
        end
        check("start_busy", 32'(BUSY), 1);
        kn[0] = 1'b1;
    endtask

    task automatic wait_result(input int lim);
        int k;
        k = 0;
        while (BUSY && k < lim) begin
            tick();
            k++;
        end
        check("result_reached", 32'(BUSY), 0);
    endtask

    initial begin
        int k;
        #5 RST_N = 1'b0;
        #1 check("reset", 32'(dut_vec), 0);
        idle(2);
        RST_N = 1'b1;

        // Voter keys in IDLE do nothing.
        hold(4'b0010, 10); idle(8);
        hold(4'b0100, 10); idle(8);
        check("idle_ignore", 32'({BUSY, YES_CNT, LED_VOTED}), 0);

        // A and B vote, C abstains: session ends on timeout and passes.
        start_session();
        idle(4);
        hold(4'b0010, 10); idle(8);
        hold(4'b0100, 10);
        wait_result(150);
        check("s1_yes", 32'(YES_CNT), 2);
        check("s1_voted", 32'(LED_VOTED), 3'b011);
        check("s1_pass", 32'({LED_PASS, LED_FAIL}), 2'b10);
        check("s1_window", busy_cycles, WIN);
        idle(3);
        check("s1_done_once", done_cnt, 1);

        // All three vote: early finish.
        idle(8);
        start_session();
        hold(4'b0010, 6); idle(6);
        hold(4'b0100, 6); idle(6);
        hold(4'b1000, 6);
        wait_result(100);
        check("s2_yes", 32'(YES_CNT), 3);
        check("s2_pass", 32'(LED_PASS), 1);
        check("s2_early", 32'(busy_cycles < WIN), 1);

        // Restart from RESULT clears the session; then repeated A presses and a B glitch.
        idle(8);
        start_session();
        check("restart_clear", 32'({BUSY, LED_PASS, LED_FAIL, YES_CNT, LED_VOTED}), 8'h80);
        for (int r = 0; r < 3; r++) begin
            hold(4'b0010, 6); idle(6);
        end
        hold(4'b0100, 2);
        wait_result(150);
        check("s3_yes", 32'(YES_CNT), 1);
        check("s3_voted", 32'(LED_VOTED), 3'b001);
        check("s3_fail", 32'({LED_PASS, LED_FAIL}), 2'b01);

        // A and C in the same cycle.
        idle(8);
        start_session();
        kn = kn & ~4'b1010;
        k = 0;
        while (YES_CNT == 0 && k < 20) begin
            tick();
            k++;
        end
        check("dual_jump", 32'(YES_CNT), 2);
        kn = kn | 4'b1010;
        wait_result(150);
        check("dual_pass", 32'(LED_PASS), 1);

        // C's press event lands exactly on the expiry cycle.
        idle(8);
        start_session();
        hold(4'b0010, 6);
        idle(WIN - 3 - DB - 6);
        kn[3] = 1'b0;
        wait_result(20);
        kn[3] = 1'b1;
        check("exp_voted", 32'(LED_VOTED), 3'b101);
        check("exp_yes", 32'(YES_CNT), 2);
        check("exp_window", busy_cycles, WIN);

        // Asynchronous reset mid-session discards votes.
        idle(8);
        start_session();
        hold(4'b0010, 8);
        check("pre_rst_yes", 32'(YES_CNT), 1);
        RST_N = 1'b0;
        #1 check("rst_async", 32'(dut_vec), 0);
        tick();
        RST_N = 1'b1;
        idle(6);
        check("rst_waits", 32'(BUSY), 0);
        start_session();
        check("rst_clean", 32'({BUSY, LED_PASS, LED_FAIL, YES_CNT, LED_VOTED}), 8'h80);
        wait_result(150);
        check("rst_fail", 32'({YES_CNT, LED_FAIL}), 3'b001);

        // Random key activity, including glitches and start presses in every state.
        idle(8);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 9) == 0) kn[i] = ~kn[i];
            tick();
        end
        kn = 4'hF;
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
